seq_pattern_detector: RTL and testbench



---
 rtl/seq_pattern_detector.sv | 127 ++++++++++++
 tb/tb_seq_pattern_detector.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector with runtime-programmable, maskable pattern and selectable overlap mode.
// Optional saturating match counter is built when SEQ_DET_MATCH_CNT_EN is defined.
module seq_pattern_detector #(
  parameter int unsigned      PAT_W       = 3,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(1),
  parameter logic [PAT_W-1:0] DEF_MASK    = '1,
  parameter logic             DEF_OVERLAP = 1'b1,
  parameter int unsigned      CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cfg_overlap,
  input  logic             s_valid,
  input  logic             s_in,
  output logic             valid,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HUNT,
    MATCH
  } state_t;

  state_t            state;
  logic [PAT_W-1:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  pat;
  logic [PAT_W-1:0]  msk;
  logic              ovl;

  logic              accept;
  logic [PAT_W-1:0]  hist_n;
  logic [FILL_W-1:0] fill_n;
  logic              full_n;
  logic              hit;

  always_comb begin
    accept = en && s_valid && !cfg_we;
    hist_n = {hist[PAT_W-2:0], s_in};
    fill_n = (fill == FILL_FULL) ? fill : fill + 1'b1;
    full_n = (fill_n == FILL_FULL);
    hit    = full_n && (((hist_n ^ pat) & msk) == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hist  <= '0;
      fill  <= '0;
      pat   <= DEF_PATTERN;
      msk   <= DEF_MASK;
      ovl   <= DEF_OVERLAP;
    end else begin
      // Configuration loads regardless of en; the state decision below is separate.
      if (cfg_we) begin
        pat <= cfg_pattern;
        msk <= cfg_mask;
        ovl <= cfg_overlap;
      end

      if (!en) begin
        state <= IDLE;
        hist  <= '0;
        fill  <= '0;
      end else if (cfg_we) begin
        state <= FILL;
        hist  <= '0;
        fill  <= '0;
      end else if (accept) begin
        if (hit) begin
          state <= MATCH;
          if (ovl) begin
            hist <= hist_n;
            fill <= fill_n;
          end else begin
            hist <= '0;
            fill <= '0;
          end
        end else begin
          state <= full_n ? HUNT : FILL;
          hist  <= hist_n;
          fill  <= fill_n;
        end
      end else begin
        unique case (state)
          IDLE:    state <= FILL;
          MATCH:   state <= ovl ? HUNT : FILL;
          default: state <= state;
        endcase
      end
    end
  end

  assign valid = (state == MATCH);

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt;

  // Clear has priority over a coincident hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (accept && hit && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign match_cnt = cnt;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Table-driven bench for seq_pattern_detector (PAT_W=3, CNT_W=2), plus a hand-written async reset sequence.
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       cfg_we;
  logic [2:0] cfg_pattern;
  logic [2:0] cfg_mask;
  logic       cfg_overlap;
  logic       s_valid;
  logic       s_in;
  logic       valid;
  logic       cnt_clr;
  logic [1:0] match_cnt;

  int total = 0;
  int bad   = 0;

  seq_pattern_detector #(
    .PAT_W      (3),
    .DEF_PATTERN(3'b001),
    .DEF_MASK   (3'b111),
    .DEF_OVERLAP(1'b1),
    .CNT_W      (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_mask   (cfg_mask),
    .cfg_overlap(cfg_overlap),
    .s_valid    (s_valid),
    .s_in       (s_in),
    .valid      (valid),
    .cnt_clr    (cnt_clr),
    .match_cnt  (match_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       we;
    logic [2:0] pat;
    logic [2:0] msk;
    logic       ovl;
    logic       sv;
    logic       si;
    logic       clr;
    logic       ev;
    int         ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic e, logic w, logic [2:0] p, logic [2:0] m, logic o,
                              logic sv, logic si, logic c, logic ev, int ec);
    vec_t v;
    v.en = e; v.we = w; v.pat = p; v.msk = m; v.ovl = o;
    v.sv = sv; v.si = si; v.clr = c; v.ev = ev; v.ec = ec;
    return v;
  endfunction

  // Counter expectations collapse to zero when the counter is not built.
  function automatic int exp_cnt(int c);
`ifdef SEQ_DET_MATCH_CNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one row at a negedge, let one rising edge consume it, check at the next negedge.
  task automatic apply(vec_t v, string name);
    en = v.en; cfg_we = v.we; cfg_pattern = v.pat; cfg_mask = v.msk;
    cfg_overlap = v.ovl; s_valid = v.sv; s_in = v.si; cnt_clr = v.clr;
    @(negedge clk);
    chk({name, ".valid"}, int'(valid), int'(v.ev));
    chk({name, ".cnt"}, int'(match_cnt), exp_cnt(v.ec));
  endtask

  // Plain accepted bit / idle cycle helpers (en=1, no cfg, no clear).
  function automatic vec_t b(logic si, logic ev, int ec);
    return mk(1, 0, 3'b000, 3'b000, 0, 1, si, 0, ev, ec);
  endfunction
  function automatic vec_t gap(logic ev, int ec);
    return mk(1, 0, 3'b000, 3'b000, 0, 0, 0, 0, ev, ec);
  endfunction

  initial begin
    rst = 1'b1; en = 0; cfg_we = 0; cfg_pattern = '0; cfg_mask = '0;
    cfg_overlap = 0; s_valid = 0; s_in = 0; cnt_clr = 0;

    // Defaults 001: stream 1,0,0,1
    tbl.push_back(b(1, 0, 0)); tbl.push_back(b(0, 0, 0));
    tbl.push_back(b(0, 0, 0)); tbl.push_back(b(1, 1, 1));
    tbl.push_back(gap(0, 1));
    // 101 overlapping: 1,0,1,0,1
    tbl.push_back(mk(1, 1, 3'b101, 3'b111, 1, 1, 1, 1, 0, 0));
    tbl.push_back(b(1, 0, 0)); tbl.push_back(b(0, 0, 0)); tbl.push_back(b(1, 1, 1));
    tbl.push_back(b(0, 0, 1)); tbl.push_back(b(1, 1, 2)); tbl.push_back(gap(0, 2));
    // 101 non-overlapping
    tbl.push_back(mk(1, 1, 3'b101, 3'b111, 0, 1, 1, 1, 0, 0));
    tbl.push_back(b(1, 0, 0)); tbl.push_back(b(0, 0, 0)); tbl.push_back(b(1, 1, 1));
    tbl.push_back(b(0, 0, 1)); tbl.push_back(b(1, 0, 1)); tbl.push_back(gap(0, 1));
    // Masked 1x1 with two-cycle gaps between bits
    tbl.push_back(mk(1, 1, 3'b101, 3'b101, 1, 1, 1, 1, 0, 0));
    tbl.push_back(b(1, 0, 0)); tbl.push_back(gap(0, 0)); tbl.push_back(gap(0, 0));
    tbl.push_back(b(1, 0, 0)); tbl.push_back(gap(0, 0)); tbl.push_back(gap(0, 0));
    tbl.push_back(b(1, 1, 1)); tbl.push_back(gap(0, 1)); tbl.push_back(gap(0, 1));
    // cfg_we drops a concurrent bit and clears fill
    tbl.push_back(mk(1, 1, 3'b001, 3'b111, 1, 0, 0, 1, 0, 0));
    tbl.push_back(b(0, 0, 0)); tbl.push_back(b(0, 0, 0));
    tbl.push_back(mk(1, 1, 3'b001, 3'b111, 1, 1, 1, 0, 0, 0));
    tbl.push_back(b(0, 0, 0)); tbl.push_back(b(1, 0, 0));
    tbl.push_back(b(0, 0, 0)); tbl.push_back(b(0, 0, 0)); tbl.push_back(b(1, 1, 1));
    tbl.push_back(gap(0, 1));
    // en=0 clears history
    tbl.push_back(b(0, 0, 1)); tbl.push_back(b(0, 0, 1));
    tbl.push_back(mk(0, 0, 3'b000, 3'b000, 0, 1, 1, 0, 0, 1));
    tbl.push_back(b(1, 0, 1));
    // cfg while disabled, then 110
    tbl.push_back(mk(0, 1, 3'b110, 3'b111, 1, 1, 1, 0, 0, 1));
    tbl.push_back(b(1, 0, 1)); tbl.push_back(b(1, 0, 1)); tbl.push_back(b(0, 1, 2));
    tbl.push_back(gap(0, 2));
    // All-zero mask: continuous hits, counter saturation, clear beats hit
    tbl.push_back(mk(1, 1, 3'b000, 3'b000, 1, 0, 0, 1, 0, 0));
    tbl.push_back(b(0, 0, 0)); tbl.push_back(b(1, 0, 0)); tbl.push_back(b(0, 1, 1));
    tbl.push_back(b(1, 1, 2)); tbl.push_back(b(1, 1, 3)); tbl.push_back(b(0, 1, 3));
    tbl.push_back(b(1, 1, 3));
    tbl.push_back(mk(1, 0, 3'b000, 3'b000, 0, 1, 0, 1, 1, 0));
    tbl.push_back(gap(0, 0));

    repeat (2) @(negedge clk);
    chk("reset.valid", int'(valid), 0);
    chk("reset.cnt", int'(match_cnt), 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("row%0d", i));
    end

    // Async reset while valid is high, then confirm the default pattern is back.
    apply(mk(1, 1, 3'b100, 3'b111, 1, 0, 0, 1, 0, 0), "rs_cfg");
    apply(b(1, 0, 0), "rs_b1");
    apply(b(0, 0, 0), "rs_b2");
    apply(b(0, 1, 1), "rs_b3");
    #2 rst = 1'b1;
    #1;
    chk("rs_async.valid", int'(valid), 0);
    chk("rs_async.cnt", int'(match_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    apply(b(0, 0, 0), "rs_p1");
    apply(b(0, 0, 0), "rs_p2");
    apply(b(1, 1, 1), "rs_p3");
    apply(b(0, 0, 1), "rs_p4");
    apply(b(0, 0, 1), "rs_p5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
